alu_operand_stage: RTL and testbench

Registered operand stage in front of the execute datapath, feeding the arithmetic right shifter and the rest of the ALU. It accepts decoded operands from issue over a valid/ready handshake, selects operand B from rs2 or the immediate, and extracts the 5-bit shift amount. It presents A, B and shamt from a register. A 2-entry skid buffer gives full throughput with a registered `in_ready`, and a synchronous flush discards in-flight operands on branch redirect.

---
 rtl/alu_operand_stage_if.sv | 37 +++
 rtl/alu_operand_stage.sv | 125 ++++++++++++
 tb/tb_alu_operand_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Issue-side and execute-side bundle for the ALU operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int SHW  = 5,
    parameter int OPW  = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic [OPW-1:0]  in_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [SHW-1:0]  out_shamt;
    logic [OPW-1:0]  out_op;
    logic [1:0]      level;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_op, out_ready,
        output in_ready, out_valid, out_a, out_b, out_shamt, out_op, level
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_op, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_shamt, out_op, level
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Registered ALU operand stage with 2-entry skid buffer & flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int SHW  = 5,
    parameter int OPW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    alu_operand_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;
    logic [XLEN-1:0] r_main_a;
    logic [XLEN-1:0] r_main_b;
    logic [OPW-1:0]  r_main_op;
    logic [XLEN-1:0] r_skid_a;
    logic [XLEN-1:0] r_skid_b;
    logic [OPW-1:0]  r_skid_op;

    logic            w_accept;
    logic            w_xfer;
    logic [XLEN-1:0] w_sel_b;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_skid_to_main;

    // Operand B is resolved at capture so the output register is the final value.
    assign w_sel_b  = bus.in_use_imm ? bus.in_imm : bus.in_rs2;
    assign w_accept = bus.in_valid & r_in_ready;
    assign w_xfer   = bus.out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (w_xfer) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_xfer) begin
                        w_state_nxt    = ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_a  <= '0;
            r_main_b  <= '0;
            r_main_op <= '0;
            r_skid_a  <= '0;
            r_skid_b  <= '0;
            r_skid_op <= '0;
        end else begin
            if (w_load_main) begin
                r_main_a  <= bus.in_rs1;
                r_main_b  <= w_sel_b;
                r_main_op <= bus.in_op;
            end else if (w_skid_to_main) begin
                r_main_a  <= r_skid_a;
                r_main_b  <= r_skid_b;
                r_main_op <= r_skid_op;
            end
            if (w_load_skid) begin
                r_skid_a  <= bus.in_rs1;
                r_skid_b  <= w_sel_b;
                r_skid_op <= bus.in_op;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != EMPTY);
    assign bus.out_a     = r_main_a;
    assign bus.out_b     = r_main_b;
    assign bus.out_shamt = r_main_b[SHW-1:0];
    assign bus.out_op    = r_main_op;
    assign bus.level     = r_state;
endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
    localparam int XLEN = 32;
    localparam int SHW  = 5;
    localparam int OPW  = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } beat_t;

    logic clk;
    logic rst;
    logic flush;

    alu_operand_stage_if #(.XLEN(XLEN), .SHW(SHW), .OPW(OPW)) bus ();

    alu_operand_stage #(.XLEN(XLEN), .SHW(SHW), .OPW(OPW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec;
    int    n_err;
    beat_t q[$];
    logic  model_rdy;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check_value("in_ready", 32'(bus.in_ready), 32'(model_rdy));
        check_value("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check_value("level", 32'(bus.level), 32'(q.size()));
        if (q.size() != 0) begin
            check_value("out_a", bus.out_a, q[0].a);
            check_value("out_b", bus.out_b, q[0].b);
            check_value("out_shamt", 32'(bus.out_shamt), q[0].b % 32);
            check_value("out_op", 32'(bus.out_op), 32'(q[0].op));
        end
    endtask

    // Presents one cycle of stimulus, advances the model at the edge, checks at negedge.
    task automatic cycle(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic use_imm, input logic [3:0] op,
                         input logic ordy, input logic fl);
        logic  acc;
        logic  xfer;
        beat_t nb;
        bus.in_valid   = v;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_imm     = imm;
        bus.in_use_imm = use_imm;
        bus.in_op      = op;
        bus.out_ready  = ordy;
        flush          = fl;
        acc  = v & model_rdy;
        xfer = (q.size() != 0) & ordy;
        nb.a  = rs1;
        nb.b  = use_imm ? imm : rs2;
        nb.op = op;
        @(posedge clk);
        if (fl) begin
            q.delete();
            model_rdy = 1'b1;
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc) q.push_back(nb);
            model_rdy = (q.size() != 2);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, ordy, 1'b0);
    endtask

    task automatic feed(input logic [31:0] rs1, input logic ordy);
        cycle(1'b1, rs1, $urandom, $urandom, 1'b0, 4'(rs1), ordy, 1'b0);
    endtask

    initial begin
        logic [31:0] sh;
        logic        sent;
        n_vec = 0;
        n_err = 0;
        model_rdy = 1'b1;
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rs1 = '0;
        bus.in_rs2 = '0;
        bus.in_imm = '0;
        bus.in_use_imm = 1'b0;
        bus.in_op = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        check_all();
        check_value("rst_out_a", bus.out_a, 32'h0);
        check_value("rst_out_b", bus.out_b, 32'h0);
        check_value("rst_shamt", 32'(bus.out_shamt), 32'h0);
        check_value("rst_out_op", 32'(bus.out_op), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Immediate operand feeding the arithmetic shifter
        cycle(1'b1, 32'h0FFA05FF, 32'h12345678, 32'd10, 1'b1, 4'h3, 1'b1, 1'b0);
        check_value("imm_out_b", bus.out_b, 32'd10);
        sh = $signed(bus.out_a) >>> bus.out_shamt;
        check_value("shift_result", sh, 32'h0003FE81);

        // Register operand: shamt keeps only the low bits
        cycle(1'b1, 32'h11111111, 32'h0000002A, 32'hFFFFFFFF, 1'b0, 4'h5, 1'b1, 1'b0);
        check_value("rs2_shamt", 32'(bus.out_shamt), 32'h0000000A);
        idle(1'b1);

        // Full-throughput streaming
        for (int i = 0; i < 8; i++) begin
            feed(32'h100 + i, 1'b1);
            check_value("stream_rdy", 32'(bus.in_ready), 32'h1);
            check_value("stream_lvl_le1", 32'(bus.level <= 2'd1), 32'h1);
        end
        idle(1'b1);

        // Backpressure: beat 3 is held upstream until accepted
        feed(32'd1, 1'b0);
        feed(32'd2, 1'b0);
        check_value("bp_level", 32'(bus.level), 32'd2);
        check_value("bp_in_ready", 32'(bus.in_ready), 32'd0);
        feed(32'd3, 1'b0);
        sent = 1'b0;
        for (int t = 0; t < 4 && !sent; t++) begin
            sent = model_rdy;
            feed(32'd3, 1'b1);
        end
        check_value("bp_beat3_sent", 32'(sent), 32'h1);
        idle(1'b1);
        idle(1'b1);

        // Flush while FULL with a beat offered
        feed(32'hA1, 1'b0);
        feed(32'hA2, 1'b0);
        cycle(1'b1, 32'hDEAD, 32'h0, 32'h0, 1'b0, 4'h7, 1'b0, 1'b1);
        check_value("flush_level", 32'(bus.level), 32'd0);
        check_value("flush_valid", 32'(bus.out_valid), 32'd0);
        check_value("flush_rdy", 32'(bus.in_ready), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset mid-cycle while FULL
        feed(32'hB1, 1'b0);
        feed(32'hB2, 1'b0);
        #2 rst = 1'b1;
        #1;
        q.delete();
        model_rdy = 1'b1;
        check_value("arst_valid", 32'(bus.out_valid), 32'd0);
        check_value("arst_level", 32'(bus.level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        feed(32'hC0FFEE, 1'b0);
        check_value("post_rst_a", bus.out_a, 32'hC0FFEE);
        idle(1'b1);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
